uart_poll_sched: RTL and testbench

Poll scheduler for the five RS485 UART slave channels of the OrbM16 frame builder. On each `cycle_start` it broadcasts a command byte on every channel and drives the `UART_dTX`/`UART_dRX` direction pins through send, turnaround and listen phases. It then collects the 18-byte replies. A round-robin arbiter writes the reply bytes from all channels through one shared write port into the frame buffer, and per-channel done/error status is reported when the poll completes.

---
 rtl/uart_poll_sched.sv | 224 ++++++++++++++++++++++
 tb/tb_uart_poll_sched.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_poll_sched.sv
// Poll scheduler for the RS485 UART slave channels: broadcasts a command, sequences
// direction pins per channel, collects replies and funnels them through one write port.
module uart_poll_sched #(
    parameter int N_CH        = 5,
    parameter int FRAME_BYTES = 18,
    parameter int TURN_CYC    = 16,
    parameter int TIMEOUT_CYC = 40000
) (
    input  logic                clk80MHz,
    input  logic                rst,
    input  logic                cycle_start,
    input  logic [7:0]          cmd_byte,
    output logic [N_CH-1:0]     tx_start,
    output logic [7:0]          tx_data,
    input  logic [N_CH-1:0]     tx_busy,
    input  logic [N_CH-1:0]     rx_valid,
    input  logic [8*N_CH-1:0]   rx_data,
    output logic [N_CH-1:0]     UART_dTX,
    output logic [N_CH-1:0]     UART_dRX,
    output logic                wr_en,
    output logic [6:0]          wr_addr,
    output logic [7:0]          wr_data,
    output logic [N_CH-1:0]     ch_done,
    output logic [N_CH-1:0]     ch_err,
    output logic                busy,
    output logic                cycle_done
);
    localparam int PTR_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int IDX_W = $clog2(FRAME_BYTES + 1);

    typedef enum logic [2:0] {ST_IDLE, ST_SEND, ST_GUARD, ST_LISTEN, ST_DONE} state_t;

    logic             busy_q, busy_d, cycle_done_q, cycle_done_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic [PTR_W-1:0] rr_q, rr_d;
    logic             wr_en_q, wr_en_d;
    logic [6:0]       wr_addr_q, wr_addr_d;
    logic [7:0]       wr_data_q, wr_data_d;
    logic             start_acc, complete;
    logic [N_CH-1:0]  grant, pend_vec, done_st_vec;
    logic [7:0]       hold_arr [N_CH];
    logic [IDX_W-1:0] hidx_arr [N_CH];
    logic             arb_found;
    logic [PTR_W-1:0] arb_sel;

    assign start_acc = cycle_start & ~busy_q;
    assign complete  = busy_q & (&done_st_vec) & ~(|pend_vec);

    // Round-robin search starting at the pointer; first pending channel wins.
    always_comb begin
        grant     = '0;
        rr_d      = rr_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        arb_found = 1'b0;
        arb_sel   = '0;
        for (int i = 0; i < N_CH; i++) begin
            arb_sel = PTR_W'((int'(rr_q) + i) % N_CH);
            if (!arb_found && pend_vec[arb_sel]) begin
                arb_found        = 1'b1;
                grant[arb_sel]   = 1'b1;
                wr_en_d          = 1'b1;
                wr_addr_d        = 7'(int'(arb_sel) * FRAME_BYTES + int'(hidx_arr[arb_sel]));
                wr_data_d        = hold_arr[arb_sel];
                rr_d             = PTR_W'((int'(arb_sel) + 1) % N_CH);
            end
        end
    end

    always_comb begin
        busy_d       = busy_q;
        cycle_done_d = complete;
        tx_data_d    = tx_data_q;
        if (start_acc) begin
            busy_d    = 1'b1;
            tx_data_d = cmd_byte;
        end else if (complete) begin
            busy_d = 1'b0;
        end
    end

    always_ff @(posedge clk80MHz or negedge rst) begin
        if (!rst) begin
            busy_q       <= 1'b0;
            cycle_done_q <= 1'b0;
            tx_data_q    <= '0;
            rr_q         <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
        end else begin
            busy_q       <= busy_d;
            cycle_done_q <= cycle_done_d;
            tx_data_q    <= tx_data_d;
            rr_q         <= rr_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
        end
    end

    assign busy       = busy_q;
    assign cycle_done = cycle_done_q;
    assign tx_data    = tx_data_q;
    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        state_t           state_q, state_d;
        logic             first_q, first_d, seen_q, seen_d, pend_q, pend_d;
        logic             done_q, done_d, err_q, err_d, take;
        logic [7:0]       guard_q, guard_d, hold_q, hold_d;
        logic [15:0]      timer_q, timer_d;
        logic [IDX_W-1:0] cnt_q, cnt_d, hidx_q, hidx_d;

        // A byte is accepted if the holder is free or is being drained this clock.
        assign take = rx_valid[gi] & (~pend_q | grant[gi]);

        always_comb begin
            state_d = state_q;
            first_d = first_q;
            seen_d  = seen_q;
            pend_d  = pend_q & ~grant[gi];
            done_d  = done_q;
            err_d   = err_q;
            guard_d = guard_q;
            hold_d  = hold_q;
            timer_d = timer_q;
            cnt_d   = cnt_q;
            hidx_d  = hidx_q;
            case (state_q)
                ST_IDLE: begin
                    if (start_acc) begin
                        state_d = ST_SEND;
                        first_d = 1'b1;
                        seen_d  = 1'b0;
                        done_d  = 1'b0;
                        err_d   = 1'b0;
                    end
                end
                ST_SEND: begin
                    first_d = 1'b0;
                    if (tx_busy[gi]) seen_d = 1'b1;
                    if (seen_q && !tx_busy[gi]) begin
                        state_d = ST_GUARD;
                        guard_d = '0;
                    end
                end
                ST_GUARD: begin
                    if (guard_q == 8'(TURN_CYC - 1)) begin
                        state_d = ST_LISTEN;
                        timer_d = '0;
                        cnt_d   = '0;
                    end else begin
                        guard_d = guard_q + 8'd1;
                    end
                end
                ST_LISTEN: begin
                    timer_d = timer_q + 16'd1;
                    if (take) begin
                        hold_d = rx_data[8*gi +: 8];
                        hidx_d = cnt_q;
                        pend_d = 1'b1;
                        cnt_d  = cnt_q + IDX_W'(1);
                    end else if (rx_valid[gi]) begin
                        err_d = 1'b1;
                    end
                    if (take && cnt_q == IDX_W'(FRAME_BYTES - 1)) begin
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else if (timer_q == 16'(TIMEOUT_CYC - 1)) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (complete) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end

        always_ff @(posedge clk80MHz or negedge rst) begin
            if (!rst) begin
                state_q <= ST_IDLE;
                first_q <= 1'b0;
                seen_q  <= 1'b0;
                pend_q  <= 1'b0;
                done_q  <= 1'b0;
                err_q   <= 1'b0;
                guard_q <= '0;
                hold_q  <= '0;
                timer_q <= '0;
                cnt_q   <= '0;
                hidx_q  <= '0;
            end else begin
                state_q <= state_d;
                first_q <= first_d;
                seen_q  <= seen_d;
                pend_q  <= pend_d;
                done_q  <= done_d;
                err_q   <= err_d;
                guard_q <= guard_d;
                hold_q  <= hold_d;
                timer_q <= timer_d;
                cnt_q   <= cnt_d;
                hidx_q  <= hidx_d;
            end
        end

        assign pend_vec[gi]    = pend_q;
        assign done_st_vec[gi] = (state_q == ST_DONE);
        assign hold_arr[gi]    = hold_q;
        assign hidx_arr[gi]    = hidx_q;
        assign tx_start[gi]    = (state_q == ST_SEND) & first_q;
        assign UART_dTX[gi]    = (state_q == ST_SEND);
        assign UART_dRX[gi]    = (state_q == ST_SEND) | (state_q == ST_GUARD);
        assign ch_done[gi]     = done_q;
        assign ch_err[gi]      = err_q;
    end

endmodule

// File: tb/tb_uart_poll_sched.sv
// Directed bench for uart_poll_sched: full polls, direction timing, timeout, arbitration,
// overrun, reset mid-poll and busy handling.
module tb_uart_poll_sched;
    localparam int N_CH = 5;
    localparam int FB   = 18;
    localparam int TURN = 16;
    localparam int TMO  = 3000;

    logic                clk80MHz;
    logic                rst;
    logic                cycle_start;
    logic [7:0]          cmd_byte;
    logic [N_CH-1:0]     tx_start;
    logic [7:0]          tx_data;
    logic [N_CH-1:0]     tx_busy;
    logic [N_CH-1:0]     rx_valid;
    logic [8*N_CH-1:0]   rx_data;
    logic [N_CH-1:0]     UART_dTX, UART_dRX;
    logic                wr_en;
    logic [6:0]          wr_addr;
    logic [7:0]          wr_data;
    logic [N_CH-1:0]     ch_done, ch_err;
    logic                busy, cycle_done;

    uart_poll_sched #(.N_CH(N_CH), .FRAME_BYTES(FB), .TURN_CYC(TURN), .TIMEOUT_CYC(TMO)) dut (
        .clk80MHz(clk80MHz), .rst(rst), .cycle_start(cycle_start), .cmd_byte(cmd_byte),
        .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy), .rx_valid(rx_valid),
        .rx_data(rx_data), .UART_dTX(UART_dTX), .UART_dRX(UART_dRX), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .ch_done(ch_done), .ch_err(ch_err),
        .busy(busy), .cycle_done(cycle_done)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int tx_len = 20;
    int tx_cnt [N_CH];
    int wr_count, cd_count, last_wr_cyc, cd_cyc, oob_count;
    int wr_hits [90];
    logic [7:0] wr_val [90];

    initial begin
        clk80MHz = 1'b0;
        forever #5 clk80MHz = ~clk80MHz;
    end

    initial forever begin
        @(posedge clk80MHz);
        cyc++;
    end

    // Transmitter model: busy for tx_len clocks after each start strobe.
    initial begin
        tx_busy = '0;
        for (int c = 0; c < N_CH; c++) tx_cnt[c] = 0;
        forever begin
            @(negedge clk80MHz);
            for (int c = 0; c < N_CH; c++) begin
                if (!rst) tx_cnt[c] = 0;
                else if (tx_start[c]) tx_cnt[c] = tx_len;
                if (tx_cnt[c] > 0) begin
                    tx_busy[c] = 1'b1;
                    tx_cnt[c]--;
                end else begin
                    tx_busy[c] = 1'b0;
                end
            end
        end
    end

    // Write-port and completion logger.
    initial forever begin
        @(negedge clk80MHz);
        if (wr_en === 1'b1) begin
            wr_count++;
            last_wr_cyc = cyc;
            if (int'(wr_addr) < 90) begin
                wr_hits[wr_addr]++;
                wr_val[wr_addr] = wr_data;
            end else begin
                oob_count++;
            end
        end
        if (cycle_done === 1'b1) begin
            cd_count++;
            cd_cyc = cyc;
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk80MHz);
        #1;
    endtask

    task automatic clear_log();
        wr_count = 0; cd_count = 0; last_wr_cyc = 0; cd_cyc = 0; oob_count = 0;
        for (int a = 0; a < 90; a++) begin
            wr_hits[a] = 0;
            wr_val[a]  = '0;
        end
    endtask

    task automatic start_poll(input logic [7:0] cmd);
        cycle_start = 1'b1;
        cmd_byte    = cmd;
        tick();
        cycle_start = 1'b0;
    endtask

    task automatic wait_listen(output bit ok, output int lcyc);
        ok = 1'b0;
        lcyc = 0;
        for (int i = 0; i < 1000 && !ok; i++) begin
            tick();
            if (busy === 1'b1 && UART_dRX === '0 && UART_dTX === '0) begin
                ok = 1'b1;
                lcyc = cyc;
            end
        end
    endtask

    task automatic wait_cd(input int limit, output bit ok);
        ok = (cd_count > 0);
        for (int i = 0; i < limit && !ok; i++) begin
            tick();
            ok = (cd_count > 0);
        end
    endtask

    task automatic send_round(input logic [N_CH-1:0] mask, input int k);
        rx_valid = mask;
        for (int c = 0; c < N_CH; c++) rx_data[8*c +: 8] = 8'(10*k + c);
        tick();
        rx_valid = '0;
        repeat (7) tick();
    endtask

    task automatic test_reset();
        logic [50:0] obs;
        rst = 1'b0;
        repeat (3) tick();
        obs = {tx_start, tx_data, UART_dTX, UART_dRX, wr_en, wr_addr, wr_data, ch_done, ch_err, busy, cycle_done};
        total++;
        if (obs !== '0) begin bad++; $display("FAIL reset_outputs: got %h want 0", obs); end
        rst = 1'b1;
        repeat (3) tick();
        obs = {tx_start, tx_data, UART_dTX, UART_dRX, wr_en, wr_addr, wr_data, ch_done, ch_err, busy, cycle_done};
        total++;
        if (obs !== '0) begin bad++; $display("FAIL idle_outputs: got %h want 0", obs); end
        $display("[test_reset] outputs=%h", obs);
    endtask

    task automatic test_full_poll();
        bit ok;
        int lcyc, c, k, hits;
        clear_log();
        tx_len = 20;
        start_poll(8'h5A);
        total++;
        if (tx_start !== 5'h1F) begin bad++; $display("FAIL full_tx_start: got %h want 1f", tx_start); end
        total++;
        if (UART_dTX !== 5'h1F || UART_dRX !== 5'h1F) begin
            bad++; $display("FAIL full_send_dir: got dTX=%h dRX=%h want 1f 1f", UART_dTX, UART_dRX);
        end
        total++;
        if (tx_data !== 8'h5A || busy !== 1'b1) begin
            bad++; $display("FAIL full_latch: got tx_data=%h busy=%b want 5a 1", tx_data, busy);
        end
        tick();
        total++;
        if (tx_start !== 5'h00) begin bad++; $display("FAIL full_tx_start_pulse: got %h want 00", tx_start); end
        wait_listen(ok, lcyc);
        total++;
        if (!ok) begin bad++; $display("FAIL full_listen_wait: got timeout want LISTEN"); end
        for (int r = 0; r < FB; r++) send_round(5'h1F, r);
        wait_cd(100, ok);
        repeat (3) tick();
        total++;
        if (!ok) begin bad++; $display("FAIL full_cycle_done_wait: got none want pulse"); end
        total++;
        if (wr_count !== 90 || oob_count !== 0) begin
            bad++; $display("FAIL full_wr_count: got %0d (oob %0d) want 90", wr_count, oob_count);
        end
        hits = 0;
        for (int a = 0; a < 90; a++) begin
            c = a / FB; k = a % FB;
            total++;
            if (wr_hits[a] !== 1 || wr_val[a] !== 8'(10*k + c)) begin
                bad++; $display("FAIL full_frame[%0d]: got hits=%0d data=%h want 1 %h", a, wr_hits[a], wr_val[a], 8'(10*k + c));
            end else hits++;
        end
        total++;
        if (ch_done !== 5'h1F || ch_err !== 5'h00) begin
            bad++; $display("FAIL full_status: got done=%h err=%h want 1f 00", ch_done, ch_err);
        end
        total++;
        if (cd_count !== 1) begin bad++; $display("FAIL full_cd_count: got %0d want 1", cd_count); end
        total++;
        if (cd_cyc - last_wr_cyc !== 1) begin
            bad++; $display("FAIL full_cd_latency: got %0d want 1", cd_cyc - last_wr_cyc);
        end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL full_busy_clear: got %b want 0", busy); end
        $display("[test_full_poll] writes=%0d good=%0d done=%h err=%h", wr_count, hits, ch_done, ch_err);
    endtask

    task automatic test_direction();
        bit ok, saw_busy, dir_bad;
        int t_bf, t_tf, t_rf;
        clear_log();
        tx_len = 200;
        start_poll(8'hC3);
        total++;
        if (UART_dTX[0] !== 1'b1 || UART_dRX[0] !== 1'b1) begin
            bad++; $display("FAIL dir_send_levels: got dTX=%b dRX=%b want 1 1", UART_dTX[0], UART_dRX[0]);
        end
        total++;
        if (ch_done !== 5'h00 || ch_err !== 5'h00) begin
            bad++; $display("FAIL dir_status_clear: got done=%h err=%h want 00 00", ch_done, ch_err);
        end
        t_bf = -1; t_tf = -1; t_rf = -1; saw_busy = 1'b0; dir_bad = 1'b0;
        for (int i = 0; i < 600 && t_rf < 0; i++) begin
            tick();
            if (tx_busy[0]) saw_busy = 1'b1;
            if (t_bf < 0 && (UART_dTX[0] !== 1'b1 || UART_dRX[0] !== 1'b1)) dir_bad = 1'b1;
            if (saw_busy && !tx_busy[0] && t_bf < 0) t_bf = cyc;
            if (UART_dTX[0] === 1'b0 && t_tf < 0) t_tf = cyc;
            if (UART_dRX[0] === 1'b0 && t_rf < 0) t_rf = cyc;
        end
        total++;
        if (t_bf < 0 || t_tf < 0 || t_rf < 0) begin
            bad++; $display("FAIL dir_wait: got bf=%0d tf=%0d rf=%0d want all seen", t_bf, t_tf, t_rf);
        end
        total++;
        if (dir_bad) begin bad++; $display("FAIL dir_hold_send: got drop before busy fall want 1 1"); end
        total++;
        if (t_tf - t_bf !== 1) begin bad++; $display("FAIL dir_tx_fall: got %0d want 1", t_tf - t_bf); end
        total++;
        if (t_rf - t_tf !== TURN) begin bad++; $display("FAIL dir_rx_fall: got %0d want %0d", t_rf - t_tf, TURN); end
        for (int r = 0; r < FB; r++) send_round(5'h1F, r);
        wait_cd(100, ok);
        tick();
        total++;
        if (!ok || ch_done !== 5'h1F) begin
            bad++; $display("FAIL dir_complete: got cd=%0d done=%h want 1 1f", cd_count, ch_done);
        end
        tx_len = 20;
        $display("[test_direction] busy_fall=%0d tx_fall=%0d rx_fall=%0d", t_bf, t_tf, t_rf);
    endtask

    task automatic test_timeout();
        bit ok;
        int lcyc, c, k, eh;
        clear_log();
        start_poll(8'h11);
        wait_listen(ok, lcyc);
        total++;
        if (!ok) begin bad++; $display("FAIL tmo_listen_wait: got timeout want LISTEN"); end
        for (int r = 0; r < FB; r++) send_round((r < 10) ? 5'h1F : 5'h1B, r);
        total++;
        if (ch_err !== 5'h00 || busy !== 1'b1) begin
            bad++; $display("FAIL tmo_early: got err=%h busy=%b want 00 1", ch_err, busy);
        end
        wait_cd(TMO + 500, ok);
        repeat (2) tick();
        total++;
        if (!ok) begin bad++; $display("FAIL tmo_cd_wait: got none want pulse"); end
        total++;
        if (ch_err !== 5'h04 || ch_done !== 5'h1B) begin
            bad++; $display("FAIL tmo_status: got err=%h done=%h want 04 1b", ch_err, ch_done);
        end
        total++;
        if (wr_count !== 82) begin bad++; $display("FAIL tmo_wr_count: got %0d want 82", wr_count); end
        total++;
        if (cd_cyc - lcyc < TMO || cd_cyc - lcyc > TMO + 2) begin
            bad++; $display("FAIL tmo_timing: got %0d want %0d..%0d", cd_cyc - lcyc, TMO, TMO + 2);
        end
        for (int a = 0; a < 90; a++) begin
            c = a / FB; k = a % FB;
            eh = (c == 2 && k >= 10) ? 0 : 1;
            total++;
            if (wr_hits[a] !== eh || (eh == 1 && wr_val[a] !== 8'(10*k + c))) begin
                bad++; $display("FAIL tmo_frame[%0d]: got hits=%0d data=%h want %0d %h", a, wr_hits[a], wr_val[a], eh, 8'(10*k + c));
            end
        end
        $display("[test_timeout] writes=%0d done=%h err=%h listen_to_done=%0d", wr_count, ch_done, ch_err, cd_cyc - lcyc);
    endtask

    task automatic test_simul_overrun();
        bit ok;
        int lcyc, c, k;
        logic [7:0] ev;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        clear_log();
        start_poll(8'h77);
        wait_listen(ok, lcyc);
        total++;
        if (!ok) begin bad++; $display("FAIL sim_listen_wait: got timeout want LISTEN"); end
        rx_valid = 5'h1F;
        for (int cc = 0; cc < N_CH; cc++) rx_data[8*cc +: 8] = 8'(8'hA0 + cc);
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (i == 1) rx_valid = '0;
            total++;
            if (i >= 2 && i <= 6) begin
                if (wr_en !== 1'b1 || wr_addr !== 7'(FB*(i-2)) || wr_data !== 8'(8'hA0 + i - 2)) begin
                    bad++; $display("FAIL sim_write[%0d]: got en=%b addr=%0d data=%h want 1 %0d %h",
                                    i, wr_en, wr_addr, wr_data, FB*(i-2), 8'(8'hA0 + i - 2));
                end
            end else if (wr_en !== 1'b0) begin
                bad++; $display("FAIL sim_idle[%0d]: got en=%b addr=%0d want 0", i, wr_en, wr_addr);
            end
            if (i == 2) begin
                total++;
                if (ch_err !== 5'h00) begin bad++; $display("FAIL sim_no_err: got %h want 00", ch_err); end
                rx_valid = 5'h10;
                rx_data[8*4 +: 8] = 8'hEE;
            end
            if (i == 3) begin
                rx_valid = '0;
                total++;
                if (ch_err !== 5'h10) begin bad++; $display("FAIL ovr_err: got %h want 10", ch_err); end
            end
        end
        for (int r = 1; r < FB; r++) send_round(5'h1F, r);
        wait_cd(100, ok);
        repeat (2) tick();
        total++;
        if (!ok || ch_done !== 5'h1F || ch_err !== 5'h10) begin
            bad++; $display("FAIL ovr_status: got cd=%b done=%h err=%h want 1 1f 10", ok, ch_done, ch_err);
        end
        total++;
        if (wr_count !== 90) begin bad++; $display("FAIL ovr_wr_count: got %0d want 90", wr_count); end
        for (int a = 0; a < 90; a++) begin
            c = a / FB; k = a % FB;
            ev = (k == 0) ? 8'(8'hA0 + c) : 8'(10*k + c);
            total++;
            if (wr_hits[a] !== 1 || wr_val[a] !== ev) begin
                bad++; $display("FAIL ovr_frame[%0d]: got hits=%0d data=%h want 1 %h", a, wr_hits[a], wr_val[a], ev);
            end
        end
        $display("[test_simul_overrun] writes=%0d done=%h err=%h", wr_count, ch_done, ch_err);
    endtask

    task automatic test_reset_busy();
        bit ok;
        int lcyc;
        logic [50:0] obs;
        clear_log();
        start_poll(8'h5A);
        wait_listen(ok, lcyc);
        send_round(5'h1F, 0);
        send_round(5'h1F, 1);
        rst = 1'b0;
        #1;
        obs = {tx_start, tx_data, UART_dTX, UART_dRX, wr_en, wr_addr, wr_data, ch_done, ch_err, busy, cycle_done};
        total++;
        if (obs !== '0) begin bad++; $display("FAIL rb_async_clear: got %h want 0", obs); end
        repeat (3) tick();
        rst = 1'b1;
        repeat (20) tick();
        total++;
        if (cd_count !== 0 || busy !== 1'b0) begin
            bad++; $display("FAIL rb_no_cd: got cd=%0d busy=%b want 0 0", cd_count, busy);
        end
        clear_log();
        start_poll(8'h5A);
        total++;
        if (tx_start !== 5'h1F || busy !== 1'b1) begin
            bad++; $display("FAIL rb_restart: got tx_start=%h busy=%b want 1f 1", tx_start, busy);
        end
        wait_listen(ok, lcyc);
        total++;
        if (!ok) begin bad++; $display("FAIL rb_listen_wait: got timeout want LISTEN"); end
        send_round(5'h1F, 0);
        cycle_start = 1'b1;
        cmd_byte = 8'h33;
        tick();
        cycle_start = 1'b0;
        total++;
        if (tx_start !== 5'h00 || tx_data !== 8'h5A || UART_dRX !== 5'h00) begin
            bad++; $display("FAIL rb_ignore_start: got tx_start=%h tx_data=%h dRX=%h want 00 5a 00", tx_start, tx_data, UART_dRX);
        end
        for (int r = 1; r < FB; r++) send_round(5'h1F, r);
        wait_cd(100, ok);
        repeat (2) tick();
        total++;
        if (!ok || cd_count !== 1 || wr_count !== 90 || ch_done !== 5'h1F) begin
            bad++; $display("FAIL rb_complete: got cd=%0d wr=%0d done=%h want 1 90 1f", cd_count, wr_count, ch_done);
        end
        $display("[test_reset_busy] writes=%0d cd=%0d done=%h", wr_count, cd_count, ch_done);
    endtask

    initial begin
        rst = 1'b0;
        cycle_start = 1'b0;
        cmd_byte = '0;
        rx_valid = '0;
        rx_data = '0;
        clear_log();
        test_reset();
        test_full_poll();
        test_direction();
        test_timeout();
        test_simul_overrun();
        test_reset_busy();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
